// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: active-low hex
// segment codes ({dp,g,f,e,d,c,b,a}) and the display-mode encodings.
package seg_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    MODE_PC  = 2'b00,
    MODE_RS  = 2'b01,
    MODE_RT  = 2'b10,
    MODE_ALU = 2'b11
  } mode_e;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment code; decimal point
// is always dark (bit 7 set in every code).
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment controller. A debug word selected by
// sw is snapshotted once per scan frame so a frame never mixes two samples.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [1:0]  sw,
  input  logic [31:0] pc_cur,
  input  logic [31:0] pc_next,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] alu_res,
  input  logic [31:0] db_data,
  output logic [3:0]  AN,
  output logic [7:0]  dispcode
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  logic [1:0]      sw_meta, sw_sync;
  logic [CntW-1:0] div_cnt;
  logic [1:0]      idx, idx_next;
  logic [15:0]     snap, mode_word, frame_word;
  logic            tick, frame;
  logic [3:0]      nibble;
  logic [7:0]      seg;

  // Only the low byte of each 32-bit tap is ever displayed.
  logic unused_taps;
  assign unused_taps = ^{pc_cur[31:8], pc_next[31:8], rs_data[31:8], rt_data[31:8],
                         alu_res[31:8], db_data[31:8]};

  assign tick     = (div_cnt == CntMax);
  assign frame    = tick && (idx == 2'd3);
  assign idx_next = idx + 2'd1;

  always_comb begin
    mode_word = '0;
    unique case (mode_e'(sw_sync))
      MODE_PC:  mode_word = {pc_cur[7:0], pc_next[7:0]};
      MODE_RS:  mode_word = {3'b000, rs_addr, rs_data[7:0]};
      MODE_RT:  mode_word = {3'b000, rt_addr, rt_data[7:0]};
      MODE_ALU: mode_word = {alu_res[7:0], db_data[7:0]};
    endcase
  end

  // On the frame boundary digit 0 must come from the word being loaded now.
  assign frame_word = frame ? mode_word : snap;
  assign nibble     = frame_word[{idx_next, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .seg    (seg)
  );

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sw_meta <= 2'b00;
      sw_sync <= 2'b00;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      div_cnt <= '0;
      idx     <= 2'd3;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        idx <= idx_next;
      end
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      snap <= '0;
    end else if (frame) begin
      snap <= mode_word;
    end
  end

  // Anode and segment registers load together so they never disagree.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      AN       <= 4'b1111;
      dispcode <= SEG_BLANK;
    end else if (tick) begin
      AN       <= ~(4'b0001 << idx_next);
      dispcode <= seg;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with REFRESH_DIV=4: stimulus pushes the
// expected digit sequence, a monitor pops on every anode change.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sw;
  logic [31:0] pc_cur, pc_next, rs_data, rt_data, alu_res, db_data;
  logic [4:0]  rs_addr, rt_addr;
  logic [3:0]  AN;
  logic [7:0]  dispcode;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];
  logic [7:0]  seg_tab[16];

  logic        mon_en = 1'b0;
  logic        mon_first;
  logic [3:0]  prev_an;
  int          hold_cnt;
  logic [11:0] exp_v;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .Reset    (rst_n),
    .sw       (sw),
    .pc_cur   (pc_cur),
    .pc_next  (pc_next),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .alu_res  (alu_res),
    .db_data  (db_data),
    .AN       (AN),
    .dispcode (dispcode)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Queue one frame's worth of expected {AN, dispcode} for a 16-bit word.
  task automatic push_frame(input logic [15:0] word);
    logic [3:0] an;
    for (int d = 0; d < 4; d++) begin
      an = ~(4'b0001 << d);
      exp_q.push_back({an, seg_tab[word[4*d +: 4]]});
    end
  endtask

  task automatic wait_q(input int n);
    int t = 0;
    while (exp_q.size() > n && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    checks++;
    if (exp_q.size() > n) begin
      errors++;
      $display("FAIL wait_q timeout: queue=%0d required<=%0d", exp_q.size(), n);
    end
  endtask

  // First tick must land exactly 4 cycles after release; call right after release.
  task automatic check_release();
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("release_an_c%0d", k), {28'd0, AN}, (k < 4) ? 32'hF : 32'hE);
    end
  endtask

  always @(negedge clk) begin
    if (!mon_en) begin
      mon_first = 1'b1;
      prev_an   = 4'hF;
      hold_cnt  = 0;
    end else begin
      if (!mon_first) check("an_onehot_low", {31'd0, $onehot(~AN)}, 32'd1);
      if (AN != prev_an) begin
        if (!mon_first) check("digit_hold", hold_cnt, 4);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got AN=%b seg=%h expected none", AN, dispcode);
        end else begin
          exp_v = exp_q.pop_front();
          check("digit", {20'd0, AN, dispcode}, {20'd0, exp_v});
        end
        prev_an   = AN;
        hold_cnt  = 1;
        mon_first = 1'b0;
      end else begin
        hold_cnt++;
      end
    end
  end

  initial begin
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    rst_n   = 1'b0;
    sw      = 2'b00;
    pc_cur  = 32'h0040_1004;
    pc_next = 32'h0040_1008;
    rs_addr = 5'h00;
    rt_addr = 5'h07;
    rs_data = 32'h0;
    rt_data = 32'h5555_5555;
    alu_res = 32'h0;
    db_data = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_an", {28'd0, AN}, 32'hF);
    check("reset_seg", {24'd0, dispcode}, 32'hFF);

    // PC mode, two full frames
    push_frame(16'h0408);
    push_frame(16'h0408);
    mon_en = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_release();

    // ALU mode; alu_res changes mid-frame and shows only from the next frame
    wait_q(2);
    sw      = 2'b11;
    alu_res = 32'h1234_56AB;
    db_data = 32'hFFFF_FFCD;
    push_frame(16'hABCD);
    push_frame(16'h12CD);
    wait_q(6);
    alu_res = 32'h1234_5612;

    // Back to PC, then switch to RS mid-frame
    wait_q(2);
    sw      = 2'b00;
    rs_addr = 5'h1F;
    rs_data = 32'hFFFF_FF3C;
    push_frame(16'h0408);
    push_frame(16'h1F3C);
    wait_q(6);
    sw = 2'b01;
    wait_q(0);

    // Reset asserted while digit 2 is displayed
    push_frame(16'h1F3C);
    wait_q(1);
    check("digit2_before_reset", {28'd0, AN}, 32'hB);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("async_reset_an", {28'd0, AN}, 32'hF);
    check("async_reset_seg", {24'd0, dispcode}, 32'hFF);
    exp_q.delete();
    repeat (2) @(posedge clk);

    // Restart and run 64 cycles of RS mode
    for (int f = 0; f < 4; f++) push_frame(16'h1F3C);
    mon_en = 1'b1;
    #1 rst_n = 1'b1;
    check_release();
    wait_q(0);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
